// File: rtl/and_arbiter_if.sv
// Request/grant/response bundle shared by the N requesters and the AND arbiter.
// The master side drives requests and operands; the slave side is the arbiter.
interface and_arbiter_if #(
   parameter int N   = 4,
   parameter int IDW = $clog2(N)
) ();
   logic [N-1:0]   req;
   logic [N-1:0]   op_a;
   logic [N-1:0]   op_b;
   logic [N-1:0]   gnt;
   logic           rsp_valid;
   logic [IDW-1:0] rsp_id;
   logic           rsp_c;
   logic           busy;

   modport master (
      output req, op_a, op_b,
      input  gnt, rsp_valid, rsp_id, rsp_c, busy
   );

   modport slave (
      input  req, op_a, op_b,
      output gnt, rsp_valid, rsp_id, rsp_c, busy
   );
endinterface

// File: rtl/and_arbiter.sv
// Round-robin arbiter that shares one registered AND unit among N requesters.
// Each transaction takes EXEC (grant pulse) then RESP (result pulse).
module and_arbiter #(
   parameter int N   = 4,
   parameter int IDW = $clog2(N)
) (
   input  logic           clk,
   input  logic           rst,
   and_arbiter_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

   state_e         state_q, state_d;
   logic [IDW-1:0] ptr_q;
   logic [IDW-1:0] w_q;
   logic           a_q, b_q;
   logic [N-1:0]   gnt_q, gnt_d;
   logic           rsp_valid_q, rsp_valid_d;
   logic [IDW-1:0] rsp_id_q, rsp_id_d;
   logic           rsp_c_q, rsp_c_d;
   logic           busy_q, busy_d;

   logic [IDW-1:0] win_s;
   logic           found_s;
   logic           any_req_s;
   logic           arb_s;
   logic [IDW-1:0] idx_s;
   logic [N-1:0]   one_s;

   assign any_req_s = |bus.req;
   assign arb_s     = any_req_s && ((state_q == IDLE) || (state_q == RESP));
   assign one_s     = {{(N-1){1'b0}}, 1'b1};

   // Search for the first request after ptr, wrapping through N-1 back to ptr itself.
   always_comb begin
      win_s   = ptr_q;
      found_s = 1'b0;
      idx_s   = ptr_q;
      for (int i = 1; i <= N; i++) begin
         idx_s = IDW'((int'(ptr_q) + i) % N);
         if (!found_s && bus.req[idx_s]) begin
            win_s   = idx_s;
            found_s = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         gnt_q       <= {N{1'b0}};
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= {IDW{1'b0}};
         rsp_c_q     <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_c_q     <= rsp_c_d;
         busy_q      <= busy_d;
      end
   end

   // Winner, its operands and the round-robin pointer are captured only on a grant.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_q <= IDW'(N - 1);
         w_q   <= {IDW{1'b0}};
         a_q   <= 1'b0;
         b_q   <= 1'b0;
      end else if (arb_s) begin
         ptr_q <= win_s;
         w_q   <= win_s;
         a_q   <= bus.op_a[win_s];
         b_q   <= bus.op_b[win_s];
      end else begin
         ptr_q <= ptr_q;
         w_q   <= w_q;
         a_q   <= a_q;
         b_q   <= b_q;
      end
   end

   // Next-state logic; requests seen during EXEC are deliberately ignored.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = any_req_s ? EXEC : IDLE;
         EXEC:    state_d = RESP;
         RESP:    state_d = any_req_s ? EXEC : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output values for the upcoming state; rsp_id/rsp_c hold outside RESP.
   always_comb begin
      gnt_d       = {N{1'b0}};
      rsp_valid_d = 1'b0;
      rsp_id_d    = rsp_id_q;
      rsp_c_d     = rsp_c_q;
      busy_d      = (state_d != IDLE);
      if (state_d == EXEC) begin
         gnt_d = one_s << win_s;
      end else begin
         gnt_d = {N{1'b0}};
      end
      if (state_d == RESP) begin
         rsp_valid_d = 1'b1;
         rsp_id_d    = w_q;
         rsp_c_d     = a_q & b_q;
      end else begin
         rsp_valid_d = 1'b0;
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_c     = rsp_c_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_and_arbiter.sv
// Directed bench for and_arbiter: expected grants and responses are queued by the
// stimulus and popped by an independent monitor whenever the DUT presents them.
module tb_and_arbiter;
   localparam int N   = 4;
   localparam int IDW = 2;

   typedef struct packed {
      logic [IDW-1:0] id;
      logic           c;
   } rsp_t;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;

   logic [N-1:0] exp_gnt_q [$];
   rsp_t         exp_rsp_q [$];

   logic [N-1:0] cont_req [11] = '{4'b1111, 4'b1110, 4'b1111, 4'b1101, 4'b1111, 4'b1011,
                                   4'b1111, 4'b0111, 4'b1111, 4'b1110, 4'b0000};
   logic [N-1:0] cont_gnt [11] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000,
                                   4'b1000, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
   logic         tt_c [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

   always #5 clk = ~clk;

   and_arbiter_if #(.N(N), .IDW(IDW)) bus ();

   and_arbiter #(.N(N), .IDW(IDW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step(input logic [N-1:0] r, input logic [N-1:0] a, input logic [N-1:0] b);
      bus.req  = r;
      bus.op_a = a;
      bus.op_b = b;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_txn(input logic [N-1:0] g, input logic [IDW-1:0] id, input logic c);
      rsp_t e;
      e.id = id;
      e.c  = c;
      exp_gnt_q.push_back(g);
      exp_rsp_q.push_back(e);
   endtask

   // Monitor: every grant and every response must match the next queued expectation.
   always @(negedge clk) begin
      rsp_t e;
      if (bus.gnt != 4'b0000) begin
         if (exp_gnt_q.size() == 0) chk("unexpected_gnt", 32'(bus.gnt), 32'd0);
         else                       chk("gnt_order", 32'(bus.gnt), 32'(exp_gnt_q.pop_front()));
      end
      if (bus.rsp_valid === 1'b1) begin
         if (exp_rsp_q.size() == 0) begin
            chk("unexpected_rsp", 32'd1, 32'd0);
         end else begin
            e = exp_rsp_q.pop_front();
            chk("rsp_id", 32'(bus.rsp_id), 32'(e.id));
            chk("rsp_c", 32'(bus.rsp_c), 32'(e.c));
         end
      end
   end

   initial begin
      rst      = 1'b0;
      bus.req  = 4'b0000;
      bus.op_a = 4'b0000;
      bus.op_b = 4'b0000;
      @(posedge clk);
      #1;
      chk("reset_gnt", 32'(bus.gnt), 32'd0);
      chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("reset_rsp_id", 32'(bus.rsp_id), 32'd0);
      chk("reset_rsp_c", 32'(bus.rsp_c), 32'd0);
      chk("reset_busy", 32'(bus.busy), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;

      // Single request from requester 2.
      expect_txn(4'b0100, 2'd2, 1'b1);
      step(4'b0100, 4'b0100, 4'b0100);
      chk("single_gnt_c1", 32'(bus.gnt), 32'b0100);
      chk("single_busy_c1", 32'(bus.busy), 32'd1);
      step(4'b0000, 4'b0000, 4'b0000);
      chk("single_valid_c2", 32'(bus.rsp_valid), 32'd1);
      chk("single_id_c2", 32'(bus.rsp_id), 32'd2);
      chk("single_c_c2", 32'(bus.rsp_c), 32'd1);
      step(4'b0000, 4'b0000, 4'b0000);
      chk("single_busy_c3", 32'(bus.busy), 32'd0);
      chk("single_valid_c3", 32'(bus.rsp_valid), 32'd0);

      // AND truth table on requester 0, back to back through RESP arbitration.
      for (int k = 0; k < 4; k++) begin
         expect_txn(4'b0001, 2'd0, tt_c[k]);
         step(4'b0001, {3'b000, k[1]}, {3'b000, k[0]});
         chk("tt_gnt", 32'(bus.gnt), 32'b0001);
         step(4'b0000, 4'b0000, 4'b0000);
         chk("tt_rsp_c", 32'(bus.rsp_c), 32'(tt_c[k]));
      end
      step(4'b0000, 4'b0000, 4'b0000);
      chk("tt_idle_busy", 32'(bus.busy), 32'd0);

      // Reset during EXEC aborts the transaction; nothing is queued for it.
      step(4'b0010, 4'b0010, 4'b0010);
      chk("abort_gnt_pre", 32'(bus.gnt), 32'b0010);
      bus.req = 4'b0000;
      #1 rst = 1'b0;
      #1;
      chk("abort_gnt", 32'(bus.gnt), 32'd0);
      chk("abort_busy", 32'(bus.busy), 32'd0);
      chk("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("abort_rsp_c", 32'(bus.rsp_c), 32'd0);
      @(posedge clk);
      #1 rst = 1'b1;
      step(4'b0000, 4'b0000, 4'b0000);
      step(4'b0000, 4'b0000, 4'b0000);
      chk("abort_no_rsp", 32'(bus.rsp_valid), 32'd0);
      chk("abort_no_busy", 32'(bus.busy), 32'd0);

      // Full contention from the reset pointer: grants 0,1,2,3,0 every other cycle.
      expect_txn(4'b0001, 2'd0, 1'b1);
      expect_txn(4'b0010, 2'd1, 1'b0);
      expect_txn(4'b0100, 2'd2, 1'b1);
      expect_txn(4'b1000, 2'd3, 1'b0);
      expect_txn(4'b0001, 2'd0, 1'b1);
      for (int k = 0; k < 11; k++) begin
         step(cont_req[k], 4'b1111, 4'b0101);
         chk("contention_gnt", 32'(bus.gnt), 32'(cont_gnt[k]));
      end

      // Wrap: grant 3, then 1010 from ptr=3 gives 1 then 3.
      expect_txn(4'b1000, 2'd3, 1'b1);
      expect_txn(4'b0010, 2'd1, 1'b1);
      expect_txn(4'b1000, 2'd3, 1'b0);
      step(4'b1000, 4'b1000, 4'b1000);
      chk("wrap_gnt3", 32'(bus.gnt), 32'b1000);
      step(4'b0000, 4'b1010, 4'b0010);
      step(4'b1010, 4'b1010, 4'b0010);
      chk("wrap_gnt1", 32'(bus.gnt), 32'b0010);
      step(4'b1000, 4'b1010, 4'b0010);
      step(4'b1000, 4'b1010, 4'b0010);
      chk("wrap_gnt3b", 32'(bus.gnt), 32'b1000);
      step(4'b0000, 4'b1010, 4'b0010);
      step(4'b0000, 4'b0000, 4'b0000);

      // Operand change after the arbitration edge must not reach rsp_c.
      expect_txn(4'b0010, 2'd1, 1'b1);
      step(4'b0010, 4'b0010, 4'b0010);
      step(4'b0000, 4'b0000, 4'b0010);
      chk("stable_rsp_c", 32'(bus.rsp_c), 32'd1);
      step(4'b0000, 4'b0000, 4'b0000);
      chk("hold_valid", 32'(bus.rsp_valid), 32'd0);
      chk("hold_rsp_id", 32'(bus.rsp_id), 32'd1);
      chk("hold_rsp_c", 32'(bus.rsp_c), 32'd1);
      chk("hold_busy", 32'(bus.busy), 32'd0);

      step(4'b0000, 4'b0000, 4'b0000);
      step(4'b0000, 4'b0000, 4'b0000);
      chk("gnt_queue_drained", 32'(exp_gnt_q.size()), 32'd0);
      chk("rsp_queue_drained", 32'(exp_rsp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
